data_stack: RTL and testbench

// - LIFO data stack serving the control FSM's push_stack/pop_stack/rst_stack strobes.
// - Push stores stack_data_in; pop presents the previous top on stack_data_out.
// - Owns the authoritative top-of-stack count and full/empty/overflow/underflow status.
// - Sits between the control FSM and the ALU operand path (temp1/temp2 capture).

---
 rtl/stack_pkg.sv | 22 ++
 rtl/data_stack_if.sv | 38 +++
 rtl/stack_ram.sv | 25 ++
 rtl/data_stack.sv | 118 +++++++++++
 tb/tb_data_stack.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared stack defaults, pointer type and push/pop operation encodings.
package stack_pkg;

    localparam int unsigned STACK_DATA_WIDTH = 16;
    localparam int unsigned STACK_DEPTH      = 32;
    localparam int unsigned STACK_PTR_WIDTH  = $clog2(STACK_DEPTH) + 1;

    typedef logic [STACK_PTR_WIDTH-1:0] ptr_t;

    // Encoding of the control FSM strobes as {pop_stack, push_stack}
    typedef enum logic [1:0] {
        StackNop     = 2'b00,
        StackPush    = 2'b01,
        StackPop     = 2'b10,
        StackReplace = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        return stack_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Control-FSM <-> data stack bundle. peek_data exists only when STACK_PEEK_EN is defined.
interface data_stack_if #(
    parameter int unsigned DATA_WIDTH = stack_pkg::STACK_DATA_WIDTH,
    parameter int unsigned DEPTH      = stack_pkg::STACK_DEPTH
) ();
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH) + 1;

    logic                  push_stack;
    logic                  pop_stack;
    logic                  rst_stack;
    logic [DATA_WIDTH-1:0] stack_data_in;
    logic [DATA_WIDTH-1:0] stack_data_out;
    logic [PTR_WIDTH-1:0]  tos_pointer;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
`ifdef STACK_PEEK_EN
    logic [DATA_WIDTH-1:0] peek_data;
`endif

    modport master (
        output push_stack, pop_stack, rst_stack, stack_data_in,
`ifdef STACK_PEEK_EN
        input  peek_data,
`endif
        input  stack_data_out, tos_pointer, full, empty, overflow, underflow
    );

    modport slave (
        input  push_stack, pop_stack, rst_stack, stack_data_in,
`ifdef STACK_PEEK_EN
        output peek_data,
`endif
        output stack_data_out, tos_pointer, full, empty, overflow, underflow
    );

endinterface

// File: rtl/stack_ram.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one asynchronous read port.
module stack_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 32,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_stack.sv
// LIFO data stack: pointer arithmetic, sticky flags and registered pop output.
// Define STACK_PEEK_EN to add the combinational peek_data top-of-stack output.
module data_stack
    import stack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = STACK_DATA_WIDTH,
    parameter int unsigned DEPTH      = STACK_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    data_stack_if.slave  bus
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH) + 1;
    localparam int unsigned AW        = $clog2(DEPTH);

    logic [PTR_WIDTH-1:0]  tos_q, tos_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  is_full;
    logic                  is_empty;
    stack_op_e             op;

    assign is_full  = (tos_q == PTR_WIDTH'(DEPTH));
    assign is_empty = (tos_q == '0);
    assign rd_addr  = AW'(tos_q - PTR_WIDTH'(1));
    assign op       = decode_op(bus.push_stack, bus.pop_stack);

    always_comb begin
        tos_d   = tos_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_addr = AW'(tos_q);
        if (bus.rst_stack) begin
            tos_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            unique case (op)
                StackPush: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        tos_d = tos_q + PTR_WIDTH'(1);
                    end
                end
                StackPop: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        out_d = rd_data;
                        tos_d = tos_q - PTR_WIDTH'(1);
                    end
                end
                StackReplace: begin
                    if (is_empty) begin
                        // Degenerates to a push, but the pop attempt is still flagged
                        wr_en = 1'b1;
                        tos_d = tos_q + PTR_WIDTH'(1);
                        unf_d = 1'b1;
                    end else begin
                        out_d   = rd_data;
                        wr_en   = 1'b1;
                        wr_addr = rd_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tos_q <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            tos_q <= tos_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Gating with rst aborts an in-flight write while reset is asserted
    stack_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en & rst),
        .wr_addr (wr_addr),
        .wr_data (bus.stack_data_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign bus.stack_data_out = out_q;
    assign bus.tos_pointer    = tos_q;
    assign bus.full           = is_full;
    assign bus.empty          = is_empty;
    assign bus.overflow       = ovf_q;
    assign bus.underflow      = unf_q;
`ifdef STACK_PEEK_EN
    assign bus.peek_data      = is_empty ? '0 : rd_data;
`endif

endmodule

// File: tb/tb_data_stack.sv
// Directed self-checking bench for data_stack; peek checks compile in with STACK_PEEK_EN.
module tb_data_stack;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    data_stack_if bus ();

    data_stack u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given strobes; returns #1 after the edge with strobes cleared
    task automatic cycle(input logic push, input logic pop, input logic clr,
                         input logic [15:0] din);
        bus.push_stack    = push;
        bus.pop_stack     = pop;
        bus.rst_stack     = clr;
        bus.stack_data_in = din;
        @(posedge clk);
        #1;
        bus.push_stack = 1'b0;
        bus.pop_stack  = 1'b0;
        bus.rst_stack  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        bus.push_stack    = 1'b0;
        bus.pop_stack     = 1'b0;
        bus.rst_stack     = 1'b0;
        bus.stack_data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tos", 32'(bus.tos_pointer), 0);
        check("rst_out", 32'(bus.stack_data_out), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full", 32'(bus.full), 0);
        check("rst_ovf", 32'(bus.overflow), 0);
        check("rst_unf", 32'(bus.underflow), 0);
        rst = 1'b1;

        // Basic LIFO order
        cycle(1, 0, 0, 16'h0001);
        cycle(1, 0, 0, 16'h0002);
        cycle(1, 0, 0, 16'h0003);
        check("push3_tos", 32'(bus.tos_pointer), 3);
        check("push3_empty", 32'(bus.empty), 0);
        cycle(0, 1, 0, '0);
        check("pop1_out", 32'(bus.stack_data_out), 32'h0003);
        check("pop1_tos", 32'(bus.tos_pointer), 2);
        cycle(0, 0, 0, '0);
        check("pop1_hold", 32'(bus.stack_data_out), 32'h0003);
        cycle(0, 1, 0, '0);
        check("pop2_out", 32'(bus.stack_data_out), 32'h0002);
        cycle(0, 1, 0, '0);
        check("pop3_out", 32'(bus.stack_data_out), 32'h0001);
        check("pop3_empty", 32'(bus.empty), 1);

        // Underflow and clear
        cycle(0, 1, 0, '0);
        check("unf_flag", 32'(bus.underflow), 1);
        check("unf_tos", 32'(bus.tos_pointer), 0);
        check("unf_out", 32'(bus.stack_data_out), 32'h0001);
        cycle(0, 0, 0, '0);
        check("unf_sticky", 32'(bus.underflow), 1);
        cycle(0, 0, 1, '0);
        check("clr_unf", 32'(bus.underflow), 0);

        // Fill, overflow, pop from full
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 0, 16'(16'h0100 + i));
        end
        check("fill_full", 32'(bus.full), 1);
        check("fill_tos", 32'(bus.tos_pointer), 32);
        check("fill_ovf", 32'(bus.overflow), 0);
        cycle(1, 0, 0, 16'hDEAD);
        check("ovf_flag", 32'(bus.overflow), 1);
        check("ovf_tos", 32'(bus.tos_pointer), 32);
        cycle(0, 1, 0, '0);
        check("full_pop_out", 32'(bus.stack_data_out), 32'h011F);
        check("full_pop_tos", 32'(bus.tos_pointer), 31);
        check("full_pop_full", 32'(bus.full), 0);
        cycle(0, 1, 0, '0);
        check("full_pop2_out", 32'(bus.stack_data_out), 32'h011E);
        cycle(0, 0, 1, '0);
        check("clr_tos", 32'(bus.tos_pointer), 0);
        check("clr_ovf", 32'(bus.overflow), 0);
        check("clr_out_hold", 32'(bus.stack_data_out), 32'h011E);

        // Replace top
        cycle(1, 0, 0, 16'h00AA);
        cycle(1, 1, 0, 16'h00BB);
        check("repl_out", 32'(bus.stack_data_out), 32'h00AA);
        check("repl_tos", 32'(bus.tos_pointer), 1);
        check("repl_unf", 32'(bus.underflow), 0);
        cycle(0, 1, 0, '0);
        check("repl_pop_out", 32'(bus.stack_data_out), 32'h00BB);
        check("repl_pop_tos", 32'(bus.tos_pointer), 0);

        // rst_stack beats a simultaneous push
        cycle(1, 0, 0, 16'h1234);
        cycle(1, 0, 1, 16'h5678);
        check("clrpush_tos", 32'(bus.tos_pointer), 0);
        check("clrpush_ovf", 32'(bus.overflow), 0);
        check("clrpush_unf", 32'(bus.underflow), 0);

        // Push+pop on empty acts as push and flags underflow
        cycle(1, 1, 0, 16'h0C0C);
        check("pp_empty_tos", 32'(bus.tos_pointer), 1);
        check("pp_empty_unf", 32'(bus.underflow), 1);
        check("pp_empty_out", 32'(bus.stack_data_out), 32'h00BB);
        cycle(0, 1, 0, '0);
        check("pp_empty_pop", 32'(bus.stack_data_out), 32'h0C0C);
        cycle(0, 0, 1, '0);

        // Replace while full raises no flag
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 0, 16'(16'h0200 + i));
        end
        cycle(1, 1, 0, 16'h7777);
        check("repl_full_out", 32'(bus.stack_data_out), 32'h021F);
        check("repl_full_tos", 32'(bus.tos_pointer), 32);
        check("repl_full_ovf", 32'(bus.overflow), 0);
        cycle(0, 1, 0, '0);
        check("repl_full_pop", 32'(bus.stack_data_out), 32'h7777);
        cycle(0, 0, 1, '0);

`ifdef STACK_PEEK_EN
        check("peek_empty", 32'(bus.peek_data), 0);
        cycle(1, 0, 0, 16'h0F0F);
        check("peek_push", 32'(bus.peek_data), 32'h0F0F);
        check("peek_tos", 32'(bus.tos_pointer), 1);
        cycle(0, 1, 0, '0);
        check("peek_pop", 32'(bus.peek_data), 0);
`endif

        // Async reset mid-operation
        cycle(1, 0, 0, 16'h4321);
        cycle(0, 1, 0, '0);
        rst = 1'b0;
        #1;
        check("arst_tos", 32'(bus.tos_pointer), 0);
        check("arst_out", 32'(bus.stack_data_out), 0);
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
